// File: rtl/hme_ip_rgmii_pkg.sv
// Shared RGMII receive/transmit definitions: FSM states, framing bytes, CRC constants.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package hme_ip_rgmii_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        PREAMBLE = 2'd1,
        DATA     = 2'd2,
        DROP     = 2'd3
    } rx_state_e;

    localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
    localparam logic [7:0]  SFD_BYTE      = 8'hD5;
    localparam logic [31:0] CRC_POLY      = 32'hEDB88320;
    localparam logic [31:0] CRC_INIT      = 32'hFFFFFFFF;
    localparam logic [31:0] CRC_RESIDUE   = 32'hDEBB20E3;

    // In-band link speed encodings carried in RXD[2:1] during inter-frame gap
    localparam logic [1:0]  SPEED_10M     = 2'b00;
    localparam logic [1:0]  SPEED_100M    = 2'b01;
    localparam logic [1:0]  SPEED_1000M   = 2'b10;

    // End-of-frame status, MSB first: {er_seen, crc_bad, runt, long}
    typedef struct packed {
        logic er_seen;
        logic crc_bad;
        logic runt;
        logic too_long;
    } rx_status_t;

endpackage

// File: rtl/hme_ip_rgmii_rx_frame_if.sv
// Framed receive byte stream towards the MAC receive logic.
// Latency: n/a (wiring only).
// Backpressure: none; the consumer must accept every beat at line rate.
// Ports: rx_data, rx_valid, rx_sof, rx_eof, rx_err_status (valid only with rx_eof).
interface hme_ip_rgmii_rx_frame_if;
    import hme_ip_rgmii_pkg::*;

    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_sof;
    logic       rx_eof;
    rx_status_t rx_err_status;

    modport master (output rx_data, rx_valid, rx_sof, rx_eof, rx_err_status);
    modport slave  (input  rx_data, rx_valid, rx_sof, rx_eof, rx_err_status);
endinterface

// File: rtl/hme_ip_rgmii_crc32_d8.sv
// Combinational next-state of the reflected Ethernet CRC-32 for one byte, LSB first.
// Latency: 0 cycles (pure combinational).
// Backpressure: n/a.
// Ports: crc_i current register, data_i byte to absorb, crc_o updated register.
module hme_ip_rgmii_crc32_d8
    import hme_ip_rgmii_pkg::*;
(
    input  logic [31:0] crc_i,
    input  logic [7:0]  data_i,
    output logic [31:0] crc_o
);

    logic [31:0] c;

    always_comb begin
        c = crc_i;
        for (int i = 0; i < 8; i++) begin
            if (c[0] ^ data_i[i]) begin
                c = (c >> 1) ^ CRC_POLY;
            end else begin
                c = c >> 1;
            end
        end
        crc_o = c;
    end

endmodule

// File: rtl/hme_ip_rgmii_rx_frame.sv
// RGMII receive framer: DDR halves -> bytes, in-band status, preamble strip, FCS/length/RX_ER checks.
// Latency: a byte sampled at edge N appears on rx_data after edge N+2 (one-byte lookahead for eof).
// Backpressure: none; output follows line rate and cannot be stalled.
// Ports: clk_eth/rstn, per-edge RX_CTL/RXD captures in, framed stream out on rx, link status, counters.
module hme_ip_rgmii_rx_frame
    import hme_ip_rgmii_pkg::*;
#(
    parameter int MIN_LEN   = 64,
    parameter int MAX_LEN   = 1518,
    parameter int CHECK_CRC = 1
) (
    input  logic                           clk_eth,
    input  logic                           rstn,
    input  logic                           i_rx_ctl_r,
    input  logic                           i_rx_ctl_f,
    input  logic [3:0]                     i_rxd_r,
    input  logic [3:0]                     i_rxd_f,
    hme_ip_rgmii_rx_frame_if.master        rx,
    output logic                           link_up,
    output logic [1:0]                     link_speed,
    output logic                           link_duplex,
    output logic [15:0]                    frame_ok_cnt,
    output logic [15:0]                    frame_err_cnt
);

    localparam logic [15:0] MIN_LEN_W = 16'(MIN_LEN);
    localparam logic [15:0] MAX_LEN_W = 16'(MAX_LEN);

    // s1 capture stage
    logic        s1_dv_q,   s1_dv_d;
    logic        s1_er_q,   s1_er_d;
    logic [7:0]  s1_byte_q, s1_byte_d;

    rx_state_e   state_q,   state_d;

    // hold register: last absorbed byte, emitted once we know whether it is the last
    logic [7:0]  h_q,       h_d;
    logic        h_vld_q,   h_vld_d;
    logic        h_sof_q,   h_sof_d;

    logic [31:0] crc_q,     crc_d;
    logic [15:0] len_q,     len_d;
    logic        er_seen_q, er_seen_d;

    logic [7:0]  rx_data_q,   rx_data_d;
    logic        rx_valid_q,  rx_valid_d;
    logic        rx_sof_q,    rx_sof_d;
    logic        rx_eof_q,    rx_eof_d;
    rx_status_t  rx_status_q, rx_status_d;

    logic        link_up_q,     link_up_d;
    logic [1:0]  link_speed_q,  link_speed_d;
    logic        link_duplex_q, link_duplex_d;
    logic [15:0] ok_cnt_q,      ok_cnt_d;
    logic [15:0] err_cnt_q,     err_cnt_d;

    logic [31:0] crc_next;
    rx_status_t  eof_status;

    hme_ip_rgmii_crc32_d8 u_crc (
        .crc_i  (crc_q),
        .data_i (s1_byte_q),
        .crc_o  (crc_next)
    );

    // Status of the frame held in h; only meaningful once the final byte is absorbed.
    always_comb begin
        eof_status.er_seen  = er_seen_q;
        eof_status.crc_bad  = (CHECK_CRC != 0) && (crc_q != CRC_RESIDUE);
        eof_status.runt     = len_q < MIN_LEN_W;
        eof_status.too_long = len_q > MAX_LEN_W;
    end

    always_comb begin
        // RX_CTL falling sample carries DV xor ER
        s1_dv_d       = i_rx_ctl_r;
        s1_er_d       = i_rx_ctl_r ^ i_rx_ctl_f;
        s1_byte_d     = {i_rxd_f, i_rxd_r};

        state_d       = state_q;
        h_d           = h_q;
        h_vld_d       = h_vld_q;
        h_sof_d       = h_sof_q;
        crc_d         = crc_q;
        len_d         = len_q;
        er_seen_d     = er_seen_q;
        rx_data_d     = rx_data_q;
        rx_valid_d    = 1'b0;
        rx_sof_d      = 1'b0;
        rx_eof_d      = 1'b0;
        rx_status_d   = '0;
        link_up_d     = link_up_q;
        link_speed_d  = link_speed_q;
        link_duplex_d = link_duplex_q;
        ok_cnt_d      = ok_cnt_q;
        err_cnt_d     = err_cnt_q;

        unique case (state_q)
            IDLE: begin
                if (!s1_dv_q) begin
                    // er=1 here is carrier extend / false carrier: status held
                    if (!s1_er_q) begin
                        link_up_d     = s1_byte_q[0];
                        link_speed_d  = s1_byte_q[2:1];
                        link_duplex_d = s1_byte_q[3];
                    end
                end else if (s1_byte_q == PREAMBLE_BYTE) begin
                    state_d = PREAMBLE;
                end else begin
                    state_d   = DROP;
                    err_cnt_d = err_cnt_q + 16'd1;
                end
            end
            PREAMBLE: begin
                if (!s1_dv_q) begin
                    state_d = IDLE;
                end else if (s1_er_q ||
                             ((s1_byte_q != PREAMBLE_BYTE) && (s1_byte_q != SFD_BYTE))) begin
                    state_d   = DROP;
                    err_cnt_d = err_cnt_q + 16'd1;
                end else if (s1_byte_q == SFD_BYTE) begin
                    state_d   = DATA;
                    crc_d     = CRC_INIT;
                    len_d     = '0;
                    er_seen_d = 1'b0;
                    h_vld_d   = 1'b0;
                end
            end
            DATA: begin
                if (s1_dv_q) begin
                    if (h_vld_q) begin
                        rx_data_d  = h_q;
                        rx_valid_d = 1'b1;
                        rx_sof_d   = h_sof_q;
                    end
                    h_d       = s1_byte_q;
                    h_vld_d   = 1'b1;
                    h_sof_d   = !h_vld_q;
                    crc_d     = crc_next;
                    len_d     = (len_q == 16'hFFFF) ? len_q : len_q + 16'd1;
                    er_seen_d = er_seen_q | s1_er_q;
                end else begin
                    state_d = IDLE;
                    h_vld_d = 1'b0;
                    if (h_vld_q) begin
                        rx_data_d   = h_q;
                        rx_valid_d  = 1'b1;
                        rx_sof_d    = h_sof_q;
                        rx_eof_d    = 1'b1;
                        rx_status_d = eof_status;
                        if (eof_status == '0) ok_cnt_d  = ok_cnt_q + 16'd1;
                        else                  err_cnt_d = err_cnt_q + 16'd1;
                    end else begin
                        // SFD immediately followed by end of carrier
                        err_cnt_d = err_cnt_q + 16'd1;
                    end
                end
            end
            DROP: begin
                if (!s1_dv_q) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_eth or negedge rstn) begin
        if (!rstn) begin
            s1_dv_q       <= 1'b0;
            s1_er_q       <= 1'b0;
            s1_byte_q     <= '0;
            state_q       <= IDLE;
            h_q           <= '0;
            h_vld_q       <= 1'b0;
            h_sof_q       <= 1'b0;
            crc_q         <= '0;
            len_q         <= '0;
            er_seen_q     <= 1'b0;
            rx_data_q     <= '0;
            rx_valid_q    <= 1'b0;
            rx_sof_q      <= 1'b0;
            rx_eof_q      <= 1'b0;
            rx_status_q   <= '0;
            link_up_q     <= 1'b0;
            link_speed_q  <= '0;
            link_duplex_q <= 1'b0;
            ok_cnt_q      <= '0;
            err_cnt_q     <= '0;
        end else begin
            s1_dv_q       <= s1_dv_d;
            s1_er_q       <= s1_er_d;
            s1_byte_q     <= s1_byte_d;
            state_q       <= state_d;
            h_q           <= h_d;
            h_vld_q       <= h_vld_d;
            h_sof_q       <= h_sof_d;
            crc_q         <= crc_d;
            len_q         <= len_d;
            er_seen_q     <= er_seen_d;
            rx_data_q     <= rx_data_d;
            rx_valid_q    <= rx_valid_d;
            rx_sof_q      <= rx_sof_d;
            rx_eof_q      <= rx_eof_d;
            rx_status_q   <= rx_status_d;
            link_up_q     <= link_up_d;
            link_speed_q  <= link_speed_d;
            link_duplex_q <= link_duplex_d;
            ok_cnt_q      <= ok_cnt_d;
            err_cnt_q     <= err_cnt_d;
        end
    end

    assign rx.rx_data       = rx_data_q;
    assign rx.rx_valid      = rx_valid_q;
    assign rx.rx_sof        = rx_sof_q;
    assign rx.rx_eof        = rx_eof_q;
    assign rx.rx_err_status = rx_status_q;

    assign link_up       = link_up_q;
    assign link_speed    = link_speed_q;
    assign link_duplex   = link_duplex_q;
    assign frame_ok_cnt  = ok_cnt_q;
    assign frame_err_cnt = err_cnt_q;

endmodule

// File: tb/tb_hme_ip_rgmii_rx_frame.sv
// Self-checking bench for hme_ip_rgmii_rx_frame: frames built with a local CRC model, beats scoreboarded.
// Latency: expected beats are stamped with the cycle they must appear on (sample edge + 2).
// Backpressure: none exists; every expected beat must appear exactly on its cycle.
module tb_hme_ip_rgmii_rx_frame;
    import hme_ip_rgmii_pkg::*;

    logic        clk_eth = 1'b0;
    logic        rstn    = 1'b1;
    logic        i_rx_ctl_r = 1'b0;
    logic        i_rx_ctl_f = 1'b0;
    logic [3:0]  i_rxd_r = 4'h0;
    logic [3:0]  i_rxd_f = 4'h0;
    logic        link_up;
    logic [1:0]  link_speed;
    logic        link_duplex;
    logic [15:0] frame_ok_cnt;
    logic [15:0] frame_err_cnt;

    hme_ip_rgmii_rx_frame_if rx_if ();

    hme_ip_rgmii_rx_frame #(
        .MIN_LEN   (64),
        .MAX_LEN   (1518),
        .CHECK_CRC (1)
    ) dut (
        .clk_eth       (clk_eth),
        .rstn          (rstn),
        .i_rx_ctl_r    (i_rx_ctl_r),
        .i_rx_ctl_f    (i_rx_ctl_f),
        .i_rxd_r       (i_rxd_r),
        .i_rxd_f       (i_rxd_f),
        .rx            (rx_if),
        .link_up       (link_up),
        .link_speed    (link_speed),
        .link_duplex   (link_duplex),
        .frame_ok_cnt  (frame_ok_cnt),
        .frame_err_cnt (frame_err_cnt)
    );

    always #4 clk_eth = ~clk_eth;

    int cyc = 0;
    always @(posedge clk_eth) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;
    int exp_ok = 0;
    int exp_err = 0;
    bit mon_ign = 1'b0;
    logic [7:0] idle_b = 8'h00;

    typedef struct {
        logic [7:0] d;
        bit         sof;
        bit         eof;
        logic [3:0] st;
        int         at;
    } exp_t;

    exp_t       exp_q[$];
    exp_t       mon_e;
    logic [7:0] frame_q[$];

    // Scoreboard: a beat is due on the cycle stamped when its byte was driven.
    always @(posedge clk_eth) begin
        #1;
        if (!mon_ign) begin
            if (exp_q.size() > 0 && exp_q[0].at <= cyc) begin
                mon_e = exp_q.pop_front();
                checks++;
                if (rx_if.rx_valid !== 1'b1 || mon_e.at != cyc) begin
                    errors++;
                    $display("FAIL beat_timing: rx_valid=%b at cyc %0d, required rx_valid=1 at cyc %0d",
                             rx_if.rx_valid, cyc, mon_e.at);
                end else begin
                    checks++;
                    if (rx_if.rx_data !== mon_e.d) begin
                        errors++;
                        $display("FAIL beat_data: got %h, required %h (cyc %0d)", rx_if.rx_data, mon_e.d, cyc);
                    end
                    checks++;
                    if (rx_if.rx_sof !== mon_e.sof) begin
                        errors++;
                        $display("FAIL beat_sof: got %b, required %b (cyc %0d)", rx_if.rx_sof, mon_e.sof, cyc);
                    end
                    checks++;
                    if (rx_if.rx_eof !== mon_e.eof) begin
                        errors++;
                        $display("FAIL beat_eof: got %b, required %b (cyc %0d)", rx_if.rx_eof, mon_e.eof, cyc);
                    end
                    if (mon_e.eof) begin
                        checks++;
                        if (rx_if.rx_err_status !== mon_e.st) begin
                            errors++;
                            $display("FAIL eof_status: got %b, required %b", rx_if.rx_err_status, mon_e.st);
                        end
                    end
                end
            end else if (rx_if.rx_valid === 1'b1) begin
                checks++;
                errors++;
                $display("FAIL unexpected_beat: rx_valid=1 data=%h at cyc %0d, required rx_valid=0",
                         rx_if.rx_data, cyc);
            end
        end
    end

    task automatic drive(input bit dv, input bit er, input logic [7:0] b);
        @(negedge clk_eth);
        i_rx_ctl_r = dv;
        i_rx_ctl_f = dv ^ er;
        i_rxd_r    = b[3:0];
        i_rxd_f    = b[7:4];
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b0, 1'b0, idle_b);
    endtask

    // Bit-serial reflected CRC over frame_q.
    function automatic logic [31:0] bench_crc();
        logic [31:0] c;
        logic [7:0]  b;
        c = 32'hFFFFFFFF;
        foreach (frame_q[i]) begin
            b = frame_q[i];
            for (int k = 0; k < 8; k++) begin
                if (c[0] != b[k]) c = {1'b0, c[31:1]} ^ 32'hEDB88320;
                else              c = {1'b0, c[31:1]};
            end
        end
        return c;
    endfunction

    function automatic logic [3:0] model_status(input bit er);
        int len;
        len = frame_q.size();
        return {er, bench_crc() != 32'hDEBB20E3, len < 64, len > 1518};
    endfunction

    task automatic build_frame(input int n_payload);
        logic [31:0] f;
        frame_q.delete();
        for (int i = 0; i < n_payload; i++) frame_q.push_back(8'($urandom_range(0, 255)));
        f = ~bench_crc();
        frame_q.push_back(f[7:0]);
        frame_q.push_back(f[15:8]);
        frame_q.push_back(f[23:16]);
        frame_q.push_back(f[31:24]);
    endtask

    // Sends preamble, SFD, frame_q (er on byte er_idx) and one dv=0 cycle.
    task automatic send_frame(input int er_idx, input bit push);
        logic [3:0] st;
        exp_t       e;
        st = model_status(er_idx >= 0);
        repeat (7) drive(1'b1, 1'b0, 8'h55);
        drive(1'b1, 1'b0, 8'hD5);
        for (int i = 0; i < frame_q.size(); i++) begin
            drive(1'b1, i == er_idx, frame_q[i]);
            if (push) begin
                e.d   = frame_q[i];
                e.sof = (i == 0);
                e.eof = (i == frame_q.size() - 1);
                e.st  = st;
                e.at  = cyc + 3;
                exp_q.push_back(e);
            end
        end
        drive(1'b0, 1'b0, idle_b);
        if (push) begin
            if (frame_q.size() == 0 || st != 4'b0000) exp_err++;
            else                                      exp_ok++;
        end
    endtask

    task automatic wait_drain(input string name);
        for (int i = 0; i < 60 && exp_q.size() > 0; i++) @(posedge clk_eth);
        repeat (2) @(negedge clk_eth);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s_drain: %0d beats never delivered, required 0", name, exp_q.size());
        end
        exp_q.delete();
    endtask

    task automatic check_counters(input string name);
        checks++;
        if (frame_ok_cnt !== 16'(exp_ok)) begin
            errors++;
            $display("FAIL %s_ok_cnt: got %0d, required %0d", name, frame_ok_cnt, exp_ok);
        end
        checks++;
        if (frame_err_cnt !== 16'(exp_err)) begin
            errors++;
            $display("FAIL %s_err_cnt: got %0d, required %0d", name, frame_err_cnt, exp_err);
        end
    endtask

    task automatic check_link(input string name, input logic up, input logic [1:0] spd, input logic dup);
        checks++;
        if ({link_up, link_speed, link_duplex} !== {up, spd, dup}) begin
            errors++;
            $display("FAIL %s: link up/speed/duplex got %b/%b/%b, required %b/%b/%b",
                     name, link_up, link_speed, link_duplex, up, spd, dup);
        end
    endtask

    task automatic check_outputs_zero(input string name);
        checks++;
        if ({rx_if.rx_valid, rx_if.rx_sof, rx_if.rx_eof} !== 3'b000) begin
            errors++;
            $display("FAIL %s_strobes: valid/sof/eof got %b%b%b, required 000",
                     name, rx_if.rx_valid, rx_if.rx_sof, rx_if.rx_eof);
        end
        checks++;
        if ({rx_if.rx_data, rx_if.rx_err_status} !== 12'h000) begin
            errors++;
            $display("FAIL %s_data: data/status got %h/%b, required 00/0000",
                     name, rx_if.rx_data, rx_if.rx_err_status);
        end
        check_link({name, "_link"}, 1'b0, 2'b00, 1'b0);
        check_counters(name);
    endtask

    task automatic test_reset();
        #2 rstn = 1'b0;
        repeat (3) @(negedge clk_eth);
        check_outputs_zero("reset");
        rstn = 1'b1;
        idle(2);
    endtask

    task automatic test_link_status();
        idle_b = 8'h0D;
        drive(1'b0, 1'b0, idle_b);
        repeat (2) @(posedge clk_eth);
        #1;
        check_link("link_0d", 1'b1, SPEED_1000M, 1'b1);
        repeat (3) drive(1'b0, 1'b1, 8'h00);
        repeat (2) @(posedge clk_eth);
        #1;
        check_link("link_held_on_er", 1'b1, SPEED_1000M, 1'b1);
        idle_b = 8'h03;
        drive(1'b0, 1'b0, idle_b);
        repeat (2) @(posedge clk_eth);
        #1;
        check_link("link_03", 1'b1, SPEED_100M, 1'b0);
        idle_b = 8'h00;
        drive(1'b0, 1'b0, idle_b);
        repeat (2) @(posedge clk_eth);
        #1;
        check_link("link_00", 1'b0, SPEED_10M, 1'b0);
        idle_b = 8'h0D;
        idle(3);
    endtask

    task automatic test_good_frame();
        build_frame(60);
        send_frame(-1, 1'b1);
        idle(2);
        wait_drain("good");
        check_counters("good");
    endtask

    task automatic test_crc_error();
        build_frame(60);
        frame_q[10] = frame_q[10] ^ 8'h01;
        send_frame(-1, 1'b1);
        idle(2);
        wait_drain("crc");
        check_counters("crc");
    endtask

    task automatic test_length();
        build_frame(56);
        send_frame(-1, 1'b1);
        idle(2);
        wait_drain("runt");
        check_counters("runt");
        build_frame(1515);
        send_frame(-1, 1'b1);
        idle(2);
        wait_drain("long");
        check_counters("long");
    endtask

    task automatic test_rx_er();
        build_frame(60);
        send_frame(20, 1'b1);
        idle(2);
        wait_drain("rx_er");
        check_counters("rx_er");
    endtask

    task automatic test_bad_preamble();
        drive(1'b1, 1'b0, 8'h55);
        drive(1'b1, 1'b0, 8'h55);
        drive(1'b1, 1'b0, 8'h33);
        repeat (5) drive(1'b1, 1'b0, 8'hD5);
        drive(1'b0, 1'b0, idle_b);
        exp_err++;
        idle(3);
        wait_drain("bad_pre");
        check_counters("bad_pre");
    endtask

    task automatic test_back_to_back();
        frame_q.delete();
        frame_q.push_back(8'hAB);
        send_frame(-1, 1'b1);
        frame_q.delete();
        send_frame(-1, 1'b1);
        build_frame(60);
        send_frame(-1, 1'b1);
        build_frame(70);
        send_frame(-1, 1'b1);
        idle(2);
        wait_drain("b2b");
        check_counters("b2b");
    endtask

    task automatic test_reset_mid_frame();
        mon_ign = 1'b1;
        build_frame(60);
        repeat (7) drive(1'b1, 1'b0, 8'h55);
        drive(1'b1, 1'b0, 8'hD5);
        for (int i = 0; i < 20; i++) drive(1'b1, 1'b0, frame_q[i]);
        @(negedge clk_eth);
        rstn = 1'b0;
        #1;
        exp_q.delete();
        exp_ok  = 0;
        exp_err = 0;
        check_outputs_zero("mid_reset");
        idle(3);
        rstn = 1'b1;
        repeat (2) @(posedge clk_eth);
        mon_ign = 1'b0;
        idle(4);
        check_link("post_reset_link", 1'b1, SPEED_1000M, 1'b1);
        build_frame(60);
        send_frame(-1, 1'b1);
        idle(2);
        wait_drain("post_reset");
        check_counters("post_reset");
    endtask

    initial begin
        test_reset();
        test_link_status();
        test_good_frame();
        test_crc_error();
        test_length();
        test_rx_er();
        test_bad_preamble();
        test_back_to_back();
        test_reset_mid_frame();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: run did not finish in time");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/hme_ip_rgmii_rx_frame.md
Name: hme_ip_rgmii_rx_frame

Overview:
- Receive-side counterpart of the RGMII transmit path. Takes the per-edge outputs of the RXD/RX_CTL DDR input capture cells, already in the clk_eth domain.
- Reassembles GMII bytes, decodes RGMII in-band link status, strips preamble/SFD and checks FCS, length and RX_ER.
- Delivers a framed byte stream with start/end/error markers to the MAC receive logic. No backpressure; line rate only.

Parameters:
MIN_LEN, 64, minimum frame length in bytes incl. FCS; shorter frames set runt
MAX_LEN, 1518, maximum frame length in bytes incl. FCS; longer frames set long
CHECK_CRC, 1, 1 = FCS residue check enabled; 0 = crc_bad forced 0

Ports:
clk_eth  input  1  receive byte clock (125/25/2.5 MHz)
rstn  input  1  asynchronous active-low reset
i_rx_ctl_r  input  1  RX_CTL sampled on rising edge (RX_DV)
i_rx_ctl_f  input  1  RX_CTL sampled on falling edge (RX_DV xor RX_ER)
i_rxd_r  input  4  RXD sampled on rising edge (byte bits [3:0])
i_rxd_f  input  4  RXD sampled on falling edge (byte bits [7:4])
rx_data  output  8  frame byte, SFD and preamble removed, FCS included
rx_valid  output  1  rx_data valid this cycle
rx_sof  output  1  first byte after SFD
rx_eof  output  1  last byte of frame
rx_err_status  output  4  {er_seen, crc_bad, runt, long}; valid only with rx_eof
link_up  output  1  in-band link status
link_speed  output  2  00=10M, 01=100M, 10=1000M
link_duplex  output  1  1=full duplex
frame_ok_cnt  output  16  good frames, wrapping
frame_err_cnt  output  16  errored or dropped frames, wrapping

Behaviour:
- Clocking and reset: single clock clk_eth; rstn asynchronous active-low. Reset clears all outputs, counters and status to 0 and puts the FSM in IDLE.
- Reset mid-frame: the partial frame is discarded with no rx_eof and no counter update.
- Stage s1 (registered inputs): dv = ctl_r; er = ctl_r ^ ctl_f; byte = {rxd_f, rxd_r}.
- FSM, evaluated on s1:
  - IDLE:
    - dv=0, er=0: latch in-band status every cycle. link_up = byte[0], link_speed = byte[2:1], link_duplex = byte[3].
    - dv=0, er=1: carrier extend/false carrier; ignored, status held.
    - dv=1, byte=0x55: go to PREAMBLE.
    - dv=1, any other byte: go to DROP and increment frame_err_cnt.
  - PREAMBLE:
    - byte=0x55: stay.
    - byte=0xD5: go to DATA and clear the CRC, length and er_seen accumulators.
    - any other byte, or er=1: go to DROP and increment frame_err_cnt.
    - dv=0: go to IDLE silently; no counter update.
  - DATA:
    - dv=1: load the byte into hold register h, update the CRC, increment length (saturating at 0xFFFF), and OR er into er_seen.
    - dv=0: go to IDLE.
  - DROP: wait for dv=0, then go to IDLE. No output.
- Hold/emit (one-byte lookahead so rx_eof coincides with the last byte):
  - h is emitted when the next s1 byte is data (rx_eof=0), or when s1 shows dv=0 (rx_eof=1).
  - Fixed latency: byte sampled at edge N is on rx_data after edge N+2.
  - rx_valid, rx_sof and rx_eof are single-cycle pulses.
  - A lone 1-byte frame asserts rx_sof and rx_eof together.
- Zero-length frame (SFD followed by dv=0): no output; frame_err_cnt increments.
- CRC (evaluated at the eof emission, after the last byte has been absorbed):
  - Reflected polynomial 0xEDB88320, init 0xFFFFFFFF, fed LSB-first over all DATA bytes incl. FCS.
  - Frame is good when the register equals residue 0xDEBB20E3; otherwise crc_bad=1.
- Length checks: runt = length < MIN_LEN; long = length > MAX_LEN.
- Counters: at rx_eof, frame_ok_cnt increments if rx_err_status=0, else frame_err_cnt increments.
- Frame aborted by a new preamble: impossible, since DATA exits only on dv=0.
- 10/100 nibble-repeated modes are out of scope; upstream duplication logic delivers bytes at the reduced clock.

Decomposition:
- Shared package hme_ip_rgmii_pkg holds:
  - state typedef {IDLE, PREAMBLE, DATA, DROP};
  - constants PREAMBLE_BYTE=0x55, SFD_BYTE=0xD5, CRC_POLY=0xEDB88320, CRC_INIT=0xFFFFFFFF, CRC_RESIDUE=0xDEBB20E3;
  - speed encodings.
- One sub-module: hme_ip_rgmii_crc32_d8. Combinational 8-bit-per-step next-CRC function, reused later by the TX FCS generator.

Test Plan:
- Idle, ctl_r=0/ctl_f=0, rxd_r=0xD, rxd_f=0x0 → link_up=1, link_speed=10, link_duplex=1 after 2 cycles.
- 7×0x55 + 0xD5 + 60-byte payload + correct FCS (64 bytes) → 64 rx_valid beats at 2-cycle latency, sof on beat 1, eof on beat 64, status=0000, frame_ok_cnt=1.
- Same frame with payload byte 10 flipped → eof status=0100, frame_err_cnt=1.
- Good-CRC 60-byte frame → status=0010. Good-CRC 1519-byte frame → status=0001.
- ctl_f toggled (er=1) for one DATA byte → that byte still delivered, eof status bit3=1.
- Preamble 0x55,0x55,0x33 → no output, frame_err_cnt=1. rstn pulsed mid-DATA → outputs 0 immediately, no eof, the next frame parses normally.
